// File: rtl/div_share_arbiter.sv
// Round-robin front end that lets N_REQ requesters share one iterative divider.
// Screens divide-by-zero, absorbs the divider's result lag and times out a hung divider.
module div_share_arbiter #(
  parameter int DATAWIDTH  = 30,
  parameter int N_REQ      = 3,
  parameter int RESULT_LAG = 1,
  parameter int TIMEOUT    = 1023
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic [N_REQ-1:0]           i_req_valid,
  output logic [N_REQ-1:0]           o_req_ready,
  input  logic [N_REQ*DATAWIDTH-1:0] i_req_dividend,
  input  logic [N_REQ*DATAWIDTH-1:0] i_req_divisor,
  output logic [N_REQ-1:0]           o_rsp_valid,
  output logic [DATAWIDTH-1:0]       o_rsp_quotient,
  output logic [DATAWIDTH-1:0]       o_rsp_remainder,
  output logic                       o_rsp_err,
  output logic                       o_div_en,
  output logic [DATAWIDTH-1:0]       o_div_dividend,
  output logic [DATAWIDTH-1:0]       o_div_divisor,
  input  logic                       i_div_ready,
  input  logic                       i_div_vld,
  input  logic [DATAWIDTH-1:0]       i_div_quotient,
  input  logic [DATAWIDTH-1:0]       i_div_remainder,
  output logic [2:0]                 o_state
);

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [GW-1:0] LAST_RST = GW'(N_REQ - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_LAG   = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  state_t                r_state;
  logic [GW-1:0]         r_last_grant;
  logic [GW-1:0]         r_grant;
  logic [CW-1:0]         r_to_cnt;
  logic [N_REQ-1:0]      r_rsp_valid;
  logic [DATAWIDTH-1:0]  r_rsp_quotient;
  logic [DATAWIDTH-1:0]  r_rsp_remainder;
  logic                  r_rsp_err;
  logic [DATAWIDTH-1:0]  r_div_dividend;
  logic [DATAWIDTH-1:0]  r_div_divisor;

  logic                  w_found;
  logic [GW-1:0]         w_grant;
  logic [N_REQ-1:0]      w_grant_oh;
  logic [N_REQ-1:0]      w_cur_oh;
  logic [DATAWIDTH-1:0]  w_sel_dividend;
  logic [DATAWIDTH-1:0]  w_sel_divisor;
  logic                  w_div_zero;

  // Round-robin search starting one past the last served requester.
  always_comb begin
    int idx;
    idx            = 0;
    w_found        = 1'b0;
    w_grant        = '0;
    w_sel_dividend = '0;
    w_sel_divisor  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(r_last_grant) + k) % N_REQ;
      if (!w_found && i_req_valid[GW'(idx)]) begin
        w_found        = 1'b1;
        w_grant        = GW'(idx);
        w_sel_dividend = DATAWIDTH'(i_req_dividend >> (idx * DATAWIDTH));
        w_sel_divisor  = DATAWIDTH'(i_req_divisor >> (idx * DATAWIDTH));
      end
    end
  end

  assign w_grant_oh = N_REQ'(1) << w_grant;
  assign w_cur_oh   = N_REQ'(1) << r_grant;
  assign w_div_zero = (w_sel_divisor == '0);

  // Handshakes: a request transfers in the IDLE cycle where req_valid[i] & req_ready[i];
  // div_en is a single-cycle start issued in ISSUE once the divider reports div_ready,
  // and div_vld is honoured only in WAIT so stray completions are dropped.
  assign o_req_ready = (sys_rst_n && r_state == S_IDLE && w_found) ? w_grant_oh : '0;
  assign o_div_en    = (r_state == S_ISSUE) && i_div_ready;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state         <= S_IDLE;
      r_last_grant    <= LAST_RST;
      r_grant         <= '0;
      r_to_cnt        <= '0;
      r_rsp_valid     <= '0;
      r_rsp_quotient  <= '0;
      r_rsp_remainder <= '0;
      r_rsp_err       <= 1'b0;
      r_div_dividend  <= '0;
      r_div_divisor   <= '0;
    end else begin
      r_rsp_valid <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant        <= w_grant;
            r_div_dividend <= w_sel_dividend;
            r_div_divisor  <= w_sel_divisor;
            if (w_div_zero) begin
              r_rsp_err       <= 1'b1;
              r_rsp_quotient  <= '1;
              r_rsp_remainder <= w_sel_dividend;
              r_rsp_valid     <= w_grant_oh;
              r_state         <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (i_div_ready) begin
            r_to_cnt <= '0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          r_to_cnt <= r_to_cnt + 1'b1;
          if (i_div_vld) begin
            if (RESULT_LAG == 0) begin
              r_rsp_quotient  <= i_div_quotient;
              r_rsp_remainder <= i_div_remainder;
              r_rsp_err       <= 1'b0;
              r_rsp_valid     <= w_cur_oh;
              r_state         <= S_RESP;
            end else begin
              r_state <= S_LAG;
            end
          end else if (r_to_cnt == TO_LAST) begin
            // Counter reaches TIMEOUT on this edge: give up on the divider.
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_err       <= 1'b1;
            r_rsp_valid     <= w_cur_oh;
            r_state         <= S_RESP;
          end
        end
        S_LAG: begin
          r_rsp_quotient  <= i_div_quotient;
          r_rsp_remainder <= i_div_remainder;
          r_rsp_err       <= 1'b0;
          r_rsp_valid     <= w_cur_oh;
          r_state         <= S_RESP;
        end
        S_RESP: begin
          r_last_grant <= r_grant;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid     = r_rsp_valid;
  assign o_rsp_quotient  = r_rsp_quotient;
  assign o_rsp_remainder = r_rsp_remainder;
  assign o_rsp_err       = r_rsp_err;
  assign o_div_dividend  = r_div_dividend;
  assign o_div_divisor   = r_div_divisor;
  assign o_state         = r_state;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Directed bench for div_share_arbiter: vector table for arbitration order plus
// hand-written sequences for latency, divide-by-zero, timeout, stall and reset.
module tb_div_share_arbiter;
  localparam int DW  = 30;
  localparam int NR  = 3;
  localparam int LAG = 1;
  localparam int TO  = 40;

  logic              sys_clk   = 1'b0;
  logic              sys_rst_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [DW-1:0]     tb_dvd [NR];
  logic [DW-1:0]     tb_dvs [NR];
  logic [NR*DW-1:0]  req_dividend;
  logic [NR*DW-1:0]  req_divisor;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_quotient, rsp_remainder;
  logic              rsp_err;
  logic              div_en;
  logic [DW-1:0]     div_dividend, div_divisor;
  logic              div_ready, div_vld;
  logic [DW-1:0]     div_quotient, div_remainder;
  logic [2:0]        state;

  assign req_dividend = {tb_dvd[2], tb_dvd[1], tb_dvd[0]};
  assign req_divisor  = {tb_dvs[2], tb_dvs[1], tb_dvs[0]};

  div_share_arbiter #(.DATAWIDTH(DW), .N_REQ(NR), .RESULT_LAG(LAG), .TIMEOUT(TO)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_dividend(req_dividend), .i_req_divisor(req_divisor),
    .o_rsp_valid(rsp_valid), .o_rsp_quotient(rsp_quotient),
    .o_rsp_remainder(rsp_remainder), .o_rsp_err(rsp_err),
    .o_div_en(div_en), .o_div_dividend(div_dividend), .o_div_divisor(div_divisor),
    .i_div_ready(div_ready), .i_div_vld(div_vld),
    .i_div_quotient(div_quotient), .i_div_remainder(div_remainder),
    .o_state(state)
  );

  // clock / reset
  always #5 sys_clk = ~sys_clk;

  // divider model: div_vld D cycles after div_en, results valid one cycle later
  int            model_d     = 4;
  logic          hang        = 1'b0;
  logic          ready_block = 1'b0;
  logic          m_busy      = 1'b0;
  int            m_cnt       = 0;
  logic [DW-1:0] m_a = '0, m_b = '1, m_q = '0, m_r = '0;

  assign div_ready     = !m_busy && !ready_block;
  assign div_vld       = m_busy && (m_cnt == 1);
  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  always @(posedge sys_clk) begin
    if (div_en && !hang) begin
      m_busy <= 1'b1;
      m_cnt  <= model_d;
      m_a    <= div_dividend;
      m_b    <= div_divisor;
      m_q    <= 30'h2AAAAAAA;
      m_r    <= 30'h15555555;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_q    <= m_a / m_b;
        m_r    <= m_a % m_b;
      end
    end
  end

  // scoreboard
  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // driver tasks: inputs change #1 after posedge, outputs sampled at negedge
  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic settle();
    @(negedge sys_clk);
  endtask

  task automatic do_accept(input logic [NR-1:0] mask, output logic [NR-1:0] rdy);
    int n;
    next_cycle();
    req_valid = mask;
    settle();
    n = 0;
    while (req_ready == '0 && n < 20) begin
      next_cycle();
      settle();
      n++;
    end
    rdy = req_ready;
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL accept_wait: req_ready still 0 after 20 cycles, mask=%b", mask);
    end
  endtask

  // Cycles counted from the accept cycle (0); div_ready is held low while lat < rel.
  task automatic wait_rsp(input int max, input int rel, input logic [DW-1:0] ea,
                          input logic [DW-1:0] eb, output int lat, output int en_cyc,
                          output int en_cnt, output logic stable);
    logic done;
    lat = 0; en_cyc = -1; en_cnt = 0; stable = 1'b1; done = 1'b0;
    while (!done && lat < max) begin
      next_cycle();
      req_valid   = '0;
      lat++;
      ready_block = (lat < rel);
      settle();
      if (div_en) begin
        en_cnt++;
        if (en_cyc < 0) en_cyc = lat;
      end
      if (rsp_valid != '0) done = 1'b1;
      else if (div_dividend !== ea || div_divisor !== eb) stable = 1'b0;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait: no rsp_valid within %0d cycles", max);
    end
  endtask

  typedef struct {
    logic [NR-1:0] mask;
    int            grant;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
  } vec_t;

  vec_t vecs[8];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [NR-1:0] rdy;
    int lat, en_cyc, en_cnt, stray;
    logic stable;

    tb_dvd[0] = 30'd4700; tb_dvs[0] = 30'd100;
    tb_dvd[1] = 30'd1000; tb_dvs[1] = 30'd7;
    tb_dvd[2] = 30'd999;  tb_dvs[2] = 30'd10;

    // held masks; grant follows round robin from last_grant+1 (reset last_grant=2)
    vecs[0] = '{3'b111, 0, 30'd47,  30'd0};
    vecs[1] = '{3'b110, 1, 30'd142, 30'd6};
    vecs[2] = '{3'b100, 2, 30'd99,  30'd9};
    vecs[3] = '{3'b010, 1, 30'd142, 30'd6};
    vecs[4] = '{3'b101, 2, 30'd99,  30'd9};
    vecs[5] = '{3'b101, 0, 30'd47,  30'd0};
    vecs[6] = '{3'b011, 1, 30'd142, 30'd6};
    vecs[7] = '{3'b011, 0, 30'd47,  30'd0};

    // reset state, with requests pending during reset
    req_valid = 3'b111;
    #2;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_q", rsp_quotient, 0);
    check("rst_rsp_r", rsp_remainder, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_div_en", div_en, 0);
    check("rst_div_dvd", div_dividend, 0);
    check("rst_div_dvs", div_divisor, 0);
    check("rst_state", state, 0);
    req_valid = '0;
    #20;
    sys_rst_n = 1'b1;

    // table: arbitration order with D=4 -> rsp at cycle 2+4+1 = 7
    model_d = 4;
    for (int i = 0; i < 8; i++) begin
      do_accept(vecs[i].mask, rdy);
      check($sformatf("v%0d_ready", i), rdy, 3'b001 << vecs[i].grant);
      exp_q.push_back(vecs[i].q);
      wait_rsp(20, 0, tb_dvd[vecs[i].grant], tb_dvs[vecs[i].grant], lat, en_cyc, en_cnt, stable);
      check($sformatf("v%0d_lat", i), lat, 7);
      check($sformatf("v%0d_en_cyc", i), en_cyc, 1);
      check($sformatf("v%0d_rsp_valid", i), rsp_valid, 3'b001 << vecs[i].grant);
      check($sformatf("v%0d_quot", i), rsp_quotient, exp_q.pop_front());
      check($sformatf("v%0d_rem", i), rsp_remainder, vecs[i].r);
      check($sformatf("v%0d_err", i), rsp_err, 0);
      check($sformatf("v%0d_stable", i), stable, 1);
    end

    // D=30: div_en at cycle 1, rsp_valid at cycle 33
    model_d = 30;
    do_accept(3'b001, rdy);
    check("d30_ready", rdy, 3'b001);
    wait_rsp(60, 0, 30'd4700, 30'd100, lat, en_cyc, en_cnt, stable);
    check("d30_lat", lat, 33);
    check("d30_en_cyc", en_cyc, 1);
    check("d30_en_cnt", en_cnt, 1);
    check("d30_rsp_valid", rsp_valid, 3'b001);
    check("d30_quot", rsp_quotient, 47);
    check("d30_rem", rsp_remainder, 0);
    check("d30_err", rsp_err, 0);
    check("d30_stable", stable, 1);
    next_cycle();
    settle();
    check("d30_pulse_end", rsp_valid, 0);
    check("d30_quot_hold", rsp_quotient, 47);
    check("d30_idle", state, 0);

    // divide by zero: no div_en, rsp at cycle 1
    model_d = 4;
    tb_dvd[2] = 30'd123; tb_dvs[2] = 30'd0;
    do_accept(3'b100, rdy);
    check("dz_ready", rdy, 3'b100);
    wait_rsp(5, 0, 30'd123, 30'd0, lat, en_cyc, en_cnt, stable);
    check("dz_lat", lat, 1);
    check("dz_en_cnt", en_cnt, 0);
    check("dz_rsp_valid", rsp_valid, 3'b100);
    check("dz_quot", rsp_quotient, 30'h3FFFFFFF);
    check("dz_rem", rsp_remainder, 123);
    check("dz_err", rsp_err, 1);
    tb_dvd[2] = 30'd999; tb_dvs[2] = 30'd10;

    // hung divider: WAIT from cycle 2, counter reaches TO after TO cycles -> rsp at TO+2
    hang = 1'b1;
    do_accept(3'b010, rdy);
    check("to_ready", rdy, 3'b010);
    wait_rsp(80, 0, 30'd1000, 30'd7, lat, en_cyc, en_cnt, stable);
    check("to_lat", lat, TO + 2);
    check("to_en_cnt", en_cnt, 1);
    check("to_rsp_valid", rsp_valid, 3'b010);
    check("to_quot", rsp_quotient, 0);
    check("to_rem", rsp_remainder, 0);
    check("to_err", rsp_err, 1);
    hang = 1'b0;
    do_accept(3'b010, rdy);
    wait_rsp(20, 0, 30'd1000, 30'd7, lat, en_cyc, en_cnt, stable);
    check("after_to_lat", lat, 7);
    check("after_to_quot", rsp_quotient, 142);
    check("after_to_rem", rsp_remainder, 6);
    check("after_to_err", rsp_err, 0);

    // div_vld in the same cycle the timeout would fire: result wins
    model_d = TO;
    do_accept(3'b001, rdy);
    wait_rsp(80, 0, 30'd4700, 30'd100, lat, en_cyc, en_cnt, stable);
    check("coinc_lat", lat, TO + 3);
    check("coinc_quot", rsp_quotient, 47);
    check("coinc_err", rsp_err, 0);

    // div_vld one cycle too late: timeout, then the late div_vld lands in RESP and is ignored
    model_d = TO + 1;
    do_accept(3'b001, rdy);
    wait_rsp(80, 0, 30'd4700, 30'd100, lat, en_cyc, en_cnt, stable);
    check("late_lat", lat, TO + 2);
    check("late_err", rsp_err, 1);
    check("late_quot", rsp_quotient, 0);
    next_cycle();
    settle();
    check("late_no_2nd_rsp", rsp_valid, 0);
    check("late_idle", state, 0);

    // div_ready low for cycles 1..5: div_en at 6, rsp at 6+4+2 = 12
    model_d = 4;
    ready_block = 1'b1;
    do_accept(3'b001, rdy);
    wait_rsp(30, 6, 30'd4700, 30'd100, lat, en_cyc, en_cnt, stable);
    check("stall_en_cyc", en_cyc, 6);
    check("stall_en_cnt", en_cnt, 1);
    check("stall_lat", lat, 12);
    check("stall_quot", rsp_quotient, 47);
    check("stall_stable", stable, 1);

    // reset during WAIT
    model_d = 30;
    do_accept(3'b010, rdy);
    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      req_valid = '0;
      settle();
    end
    check("mid_state_wait", state, 2);
    next_cycle();
    req_valid = 3'b011;
    sys_rst_n = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_div_en", div_en, 0);
    check("mid_rst_div_dvd", div_dividend, 0);
    check("mid_rst_div_dvs", div_divisor, 0);
    check("mid_rst_state", state, 0);
    next_cycle();
    next_cycle();
    req_valid = '0;
    #2;
    sys_rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      settle();
      if (rsp_valid != '0) stray++;
    end
    check("mid_rst_no_rsp", stray, 0);
    check("mid_rst_idle", state, 0);
    model_d = 4;
    do_accept(3'b011, rdy);
    check("post_rst_grant", rdy, 3'b001);
    wait_rsp(20, 0, 30'd4700, 30'd100, lat, en_cyc, en_cnt, stable);
    check("post_rst_lat", lat, 7);
    check("post_rst_quot", rsp_quotient, 47);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
